// File: rtl/msx_mouse_port.sv
// msx_mouse_port
//
// Adapts a host mouse (relative X/Y deltas plus buttons) to the MSX
// general-purpose joystick port. Two modes share the port:
//   - joystick mode: the joystick lines are passed through, and the port
//     is blanked while pin-8 strobe is high;
//   - mouse mode: motion is accumulated into 8-bit saturating counters and
//     read out four nibbles at a time. The MSX toggles strobe and each edge
//     presents the next nibble (X high, X low, Y high, Y low).
// Any mouse report switches to mouse mode. Any joystick activity without a
// mouse report switches back and discards all pending motion.
//
// Ports:
//   clk_sys      in   system clock, everything is rising-edge
//   reset_n      in   asynchronous active-low reset
//   mouse_strobe in   one-cycle pulse, mouse_x/mouse_y/mouse_flags valid
//   mouse_x      in   9-bit signed X delta, positive = right
//   mouse_y      in   9-bit signed Y delta
//   mouse_flags  in   bit0 left button, bit1 right button (active-high)
//   joy_in       in   active-low joystick lines, [3:0] dirs, [5:4] triggers
//   strobe       in   MSX pin-8 strobe, synchronous to clk_sys
//   port_out     out  active-low lines presented to the MSX port
//   mouse_en     out  1 = mouse mode, 0 = joystick mode
//   phase        out  current nibble read phase (debug)

module msx_mouse_port #(
    parameter int TIMEOUT = 100000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       mouse_strobe,
    input  logic [8:0] mouse_x,
    input  logic [8:0] mouse_y,
    input  logic [7:0] mouse_flags,
    input  logic [5:0] joy_in,
    input  logic       strobe,
    output logic [5:0] port_out,
    output logic       mouse_en,
    output logic [1:0] phase
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT);

    // Read phase names which nibble the next strobe edge will present.
    typedef enum logic [1:0] {
        PH_X_HI = 2'd0,
        PH_X_LO = 2'd1,
        PH_Y_HI = 2'd2,
        PH_Y_LO = 2'd3
    } readPhase_t;

    // Clamp a 10-bit signed intermediate into the 8-bit signed range.
    function automatic logic [7:0] sat8(input logic [9:0] v);
        logic [7:0] result;
        if (!v[9] && (v[8:7] != 2'b00)) begin
            result = 8'h7F;
        end else if (v[9] && (v[8:7] != 2'b11)) begin
            result = 8'h80;
        end else begin
            result = v[7:0];
        end
        return result;
    endfunction

    readPhase_t    phase_q, phase_d;
    logic          mouseEn_q, mouseEn_d;
    logic [5:0]    portOut_q, portOut_d;
    logic [7:0]    accX_q, accX_d;
    logic [7:0]    accY_q, accY_d;
    // The X high nibble goes out straight from the accumulator at the
    // phase-0 edge, so only the X low nibble has to be held for later.
    logic [3:0]    snapXLo_q, snapXLo_d;
    logic [7:0]    snapY_q, snapY_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          strbDly_q;

    logic          strobeEdge;
    logic          joyActive;
    logic          mouseMode;
    logic [7:0]    baseX, baseY;
    logic [9:0]    sumX, sumY;
    logic          unusedFlags;

    assign unusedFlags = ^mouse_flags[7:2];

    // Next-state logic. mouseMode is the mode this cycle ends up in: a mouse
    // report always wins, otherwise joystick activity drops back to
    // joystick mode. A phase-0 edge takes the snapshot and restarts the
    // accumulators from zero, and a coincident report lands on that zero
    // base, so no motion is lost.
    always_comb begin
        strobeEdge = (strobe != strbDly_q);
        joyActive  = (joy_in != 6'h3F);
        mouseMode  = mouse_strobe || (mouseEn_q && !joyActive);

        baseX = (strobeEdge && (phase_q == PH_X_HI)) ? 8'h00 : accX_q;
        baseY = (strobeEdge && (phase_q == PH_X_HI)) ? 8'h00 : accY_q;
        sumX  = {{2{baseX[7]}}, baseX} - {mouse_x[8], mouse_x};
        sumY  = {{2{baseY[7]}}, baseY} + {mouse_y[8], mouse_y};

        phase_d   = phase_q;
        mouseEn_d = mouseMode;
        portOut_d = portOut_q;
        accX_d    = accX_q;
        accY_d    = accY_q;
        snapXLo_d = snapXLo_q;
        snapY_d   = snapY_q;
        timer_d   = timer_q;

        if (!mouseMode) begin
            phase_d   = PH_X_HI;
            accX_d    = 8'h00;
            accY_d    = 8'h00;
            snapXLo_d = 4'h0;
            snapY_d   = 8'h00;
            timer_d   = '0;
            portOut_d = strobe ? 6'h3F : joy_in;
        end else begin
            if (mouse_strobe) begin
                portOut_d[5:4] = ~mouse_flags[1:0];
                accX_d = sat8(sumX);
                accY_d = sat8(sumY);
            end else begin
                accX_d = baseX;
                accY_d = baseY;
            end

            // An edge beats the timeout, even on the cycle the count expires.
            if (strobeEdge) begin
                timer_d = TIMEOUT_LOAD;
                phase_d = readPhase_t'(phase_q + 2'd1);
                unique case (phase_q)
                    PH_X_HI: begin
                        snapXLo_d      = accX_q[3:0];
                        snapY_d        = accY_q;
                        portOut_d[3:0] = accX_q[7:4];
                    end
                    PH_X_LO: portOut_d[3:0] = snapXLo_q;
                    PH_Y_HI: portOut_d[3:0] = snapY_q[7:4];
                    PH_Y_LO: portOut_d[3:0] = snapY_q[3:0];
                    default: portOut_d[3:0] = portOut_q[3:0];
                endcase
            end else if (timer_q != '0) begin
                timer_d = timer_q - TW'(1);
                if (timer_q == TW'(1)) begin
                    phase_d = PH_X_HI;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= PH_X_HI;
            mouseEn_q <= 1'b0;
            portOut_q <= 6'h3F;
            accX_q    <= 8'h00;
            accY_q    <= 8'h00;
            snapXLo_q <= 4'h0;
            snapY_q   <= 8'h00;
            timer_q   <= '0;
            strbDly_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            mouseEn_q <= mouseEn_d;
            portOut_q <= portOut_d;
            accX_q    <= accX_d;
            accY_q    <= accY_d;
            snapXLo_q <= snapXLo_d;
            snapY_q   <= snapY_d;
            timer_q   <= timer_d;
            strbDly_q <= strobe;
        end
    end

    assign port_out = portOut_q;
    assign mouse_en = mouseEn_q;
    assign phase    = phase_q;

endmodule

// File: tb/tb_msx_mouse_port.sv
// tb_msx_mouse_port
//
// Bench for msx_mouse_port. A reference model steps once per driven cycle
// and queues the outputs expected after the next clock; a monitor pops and
// compares them just after each rising edge. Directed sequences cover the
// joystick pass-through, a full nibble readout, saturation, timeout,
// report/edge coincidence, mode exit and async reset; a random phase follows.

module tb_msx_mouse_port;

    localparam int TO = 16;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       mouse_strobe = 1'b0;
    logic [8:0] mouse_x = '0;
    logic [8:0] mouse_y = '0;
    logic [7:0] mouse_flags = '0;
    logic [5:0] joy_in = 6'h3F;
    logic       strobe = 1'b0;
    logic [5:0] port_out;
    logic       mouse_en;
    logic [1:0] phase;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [5:0] port;
        logic       en;
        logic [1:0] ph;
    } exp_t;

    exp_t expQ[$];

    // Model state: plain integers, with the four readout nibbles computed
    // in one go whenever a new frame is captured.
    logic       mEn;
    int         mPhase;
    int         mTimer;
    int         mAccX;
    int         mAccY;
    int         nib[4];
    logic [5:0] mPort;
    logic       mPrev;
    logic       stbLevel;

    msx_mouse_port #(.TIMEOUT(TO)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .mouse_strobe(mouse_strobe),
        .mouse_x     (mouse_x),
        .mouse_y     (mouse_y),
        .mouse_flags (mouse_flags),
        .joy_in      (joy_in),
        .strobe      (strobe),
        .port_out    (port_out),
        .mouse_en    (mouse_en),
        .phase       (phase)
    );

    // Free-running system clock, rising edges at 5, 15, 25 ...
    initial begin
        forever #5 clk_sys = ~clk_sys;
    end

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic void modelReset();
        mEn    = 1'b0;
        mPhase = 0;
        mTimer = 0;
        mAccX  = 0;
        mAccY  = 0;
        for (int i = 0; i < 4; i++) nib[i] = 0;
        mPort  = 6'h3F;
        mPrev  = 1'b0;
    endfunction

    // One clock of behaviour: decide the mode, handle a strobe edge or the
    // timeout, then fold in any new motion report.
    function automatic void modelStep(input logic ms, input logic [8:0] mx,
                                      input logic [8:0] my, input logic [7:0] fl,
                                      input logic [5:0] joy, input logic stb);
        logic edgeSeen;
        int   dx;
        int   dy;
        int   bx;
        int   by;
        edgeSeen = (stb != mPrev);
        mPrev    = stb;
        dx       = int'($signed(mx));
        dy       = int'($signed(my));
        if (ms) mEn = 1'b1;
        else if (joy != 6'h3F) mEn = 1'b0;
        if (!mEn) begin
            mPhase = 0;
            mTimer = 0;
            mAccX  = 0;
            mAccY  = 0;
            for (int i = 0; i < 4; i++) nib[i] = 0;
            mPort  = stb ? 6'h3F : joy;
            return;
        end
        if (ms) mPort[5:4] = ~fl[1:0];
        if (edgeSeen) begin
            if (mPhase == 0) begin
                bx = mAccX & 255;
                by = mAccY & 255;
                nib[0] = bx / 16;
                nib[1] = bx % 16;
                nib[2] = by / 16;
                nib[3] = by % 16;
                mAccX = 0;
                mAccY = 0;
            end
            mPort[3:0] = 4'(nib[mPhase]);
            mPhase = (mPhase + 1) % 4;
            mTimer = TO;
        end else if (mTimer > 0) begin
            mTimer = mTimer - 1;
            if (mTimer == 0) mPhase = 0;
        end
        if (ms) begin
            mAccX = clamp8(mAccX - dx);
            mAccY = clamp8(mAccY + dy);
        end
    endfunction

    task automatic checkOutput(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Called on a falling edge: drive one cycle of inputs, queue what the
    // model predicts for after the next rising edge, then wait it out.
    task automatic applyStimulus(input logic ms, input logic [8:0] mx,
                                 input logic [8:0] my, input logic [7:0] fl,
                                 input logic [5:0] joy, input logic stb);
        exp_t e;
        mouse_strobe = ms;
        mouse_x      = mx;
        mouse_y      = my;
        mouse_flags  = fl;
        joy_in       = joy;
        strobe       = stb;
        modelStep(ms, mx, my, fl, joy, stb);
        e.port = mPort;
        e.en   = mEn;
        e.ph   = 2'(mPhase);
        expQ.push_back(e);
        @(negedge clk_sys);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 9'h0, 9'h0, 8'h0, 6'h3F, stbLevel);
    endtask

    task automatic toggleStrobe();
        stbLevel = ~stbLevel;
        applyStimulus(1'b0, 9'h0, 9'h0, 8'h0, 6'h3F, stbLevel);
    endtask

    task automatic mouseMove(input logic [8:0] mx, input logic [8:0] my, input logic [7:0] fl);
        applyStimulus(1'b1, mx, my, fl, 6'h3F, stbLevel);
    endtask

    task automatic readFrame();
        for (int i = 0; i < 4; i++) begin
            toggleStrobe();
            idle(1);
        end
    endtask

    // Monitor: just after every rising edge, compare whatever the driver
    // queued for that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_sys);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("port_out", int'(port_out), int'(e.port));
                checkOutput("mouse_en", int'(mouse_en), int'(e.en));
                checkOutput("phase", int'(phase), int'(e.ph));
            end
        end
    end

    // Main sequence of directed scenarios, random traffic, and final summary.
    initial begin
        logic       ms;
        logic [5:0] joy;
        modelReset();
        stbLevel = 1'b0;

        repeat (2) @(negedge clk_sys);
        checkOutput("reset_port_out", int'(port_out), 'h3F);
        checkOutput("reset_mouse_en", int'(mouse_en), 0);
        checkOutput("reset_phase", int'(phase), 0);
        reset_n = 1'b1;

        // Joystick pass-through and strobe blanking.
        applyStimulus(1'b0, 9'h0, 9'h0, 8'h0, 6'h3E, 1'b0);
        stbLevel = 1'b1;
        applyStimulus(1'b0, 9'h0, 9'h0, 8'h0, 6'h3E, 1'b1);
        stbLevel = 1'b0;
        applyStimulus(1'b0, 9'h0, 9'h0, 8'h0, 6'h3E, 1'b0);
        idle(2);

        // Full readout: X=+5 gives acc_x=-5, Y=-3 gives acc_y=-3.
        mouseMove(9'h005, 9'h1FD, 8'h01);
        idle(2);
        readFrame();

        // Saturation in both directions.
        for (int i = 0; i < 3; i++) mouseMove(9'h100, 9'h064, 8'h02);
        idle(1);
        readFrame();

        // Timeout back to phase 0, then an edge landing on countdown 1.
        mouseMove(9'h030, 9'h010, 8'h00);
        toggleStrobe();
        idle(1);
        toggleStrobe();
        mouseMove(9'h1E0, 9'h020, 8'h00);
        idle(TO - 1);
        toggleStrobe();
        toggleStrobe();
        idle(TO - 1);
        toggleStrobe();
        toggleStrobe();
        idle(2);

        // Report arriving on the same cycle as the phase-0 edge.
        mouseMove(9'h1F0, 9'h008, 8'h00);
        stbLevel = ~stbLevel;
        applyStimulus(1'b1, 9'h008, 9'h004, 8'h03, 6'h3F, stbLevel);
        idle(1);
        for (int i = 0; i < 3; i++) toggleStrobe();
        readFrame();

        // Joystick activity drops out of mouse mode.
        applyStimulus(1'b0, 9'h0, 9'h0, 8'h0, 6'h2F, stbLevel);
        idle(2);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            ms  = ($urandom_range(0, 4) == 0);
            joy = ($urandom_range(0, 19) == 0) ? 6'($urandom) : 6'h3F;
            if ($urandom_range(0, 2) == 0) stbLevel = ~stbLevel;
            applyStimulus(ms, 9'($urandom), 9'($urandom), 8'($urandom), joy, stbLevel);
            if ($urandom_range(0, 49) == 0) idle(TO + $urandom_range(0, 2));
        end

        // Async reset mid-cycle while in phase 2.
        idle(1);
        mouseMove(9'h011, 9'h022, 8'h00);
        idle(TO + 1);
        toggleStrobe();
        toggleStrobe();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_port_out", int'(port_out), 'h3F);
        checkOutput("async_phase", int'(phase), 0);
        checkOutput("async_mouse_en", int'(mouse_en), 0);
        @(negedge clk_sys);
        modelReset();
        stbLevel     = 1'b0;
        mouse_strobe = 1'b0;
        strobe       = 1'b0;
        joy_in       = 6'h3F;
        reset_n      = 1'b1;
        idle(2);
        mouseMove(9'h1FF, 9'h002, 8'h01);
        readFrame();

        idle(2);
        checkOutput("scoreboard_drain", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
